seg_scan_capture: RTL and testbench

- Reader side of the multiplexed seven-segment interface.
- Samples the scanned anode-select (`trigger`) and segment (`segBits`) lines that the display driver produces.
- Filters transition ghosting, then decodes each position's segment pattern back to a BCD digit. Publishes a complete 4-digit frame with flags.
- Used as an on-chip loopback checker and as the bench monitor for stopwatch display output.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_pattern_decode.sv | 29 ++
 rtl/seg_scan_capture.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan capture path.
package seg_pkg;

  // Active-low segment patterns on bits [6:0] (bit0 = a ... bit6 = g).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic [3:0] digit;
    logic       blank;
    logic       invalid;
  } seg_decode_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to BCD decoder.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0]  pattern,
  output seg_decode_t result
);

  // Look up the pattern; anything not in the table is flagged invalid.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result = '{digit: 4'd0, blank: 1'b0, invalid: 1'b1};
    case (pattern)
      SEG_0:     result = '{digit: 4'd0, blank: 1'b0, invalid: 1'b0};
      SEG_1:     result = '{digit: 4'd1, blank: 1'b0, invalid: 1'b0};
      SEG_2:     result = '{digit: 4'd2, blank: 1'b0, invalid: 1'b0};
      SEG_3:     result = '{digit: 4'd3, blank: 1'b0, invalid: 1'b0};
      SEG_4:     result = '{digit: 4'd4, blank: 1'b0, invalid: 1'b0};
      SEG_5:     result = '{digit: 4'd5, blank: 1'b0, invalid: 1'b0};
      SEG_6:     result = '{digit: 4'd6, blank: 1'b0, invalid: 1'b0};
      SEG_7:     result = '{digit: 4'd7, blank: 1'b0, invalid: 1'b0};
      SEG_8:     result = '{digit: 4'd8, blank: 1'b0, invalid: 1'b0};
      SEG_9:     result = '{digit: 4'd9, blank: 1'b0, invalid: 1'b0};
      SEG_BLANK: result = '{digit: 4'd0, blank: 1'b1, invalid: 1'b0};
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Reader for a multiplexed 4-digit seven-segment display: debounces each
// scanned position, decodes it, and publishes whole frames with flags.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        MegaClk,
  input  logic        reset,
  input  logic [3:0]  trigger,
  input  logic [7:0]  segBits,
  output logic [15:0] digits_out,
  output logic [3:0]  blank_mask,
  output logic [3:0]  invalid_mask,
  output logic [3:0]  dp_mask,
  output logic        frame_valid,
  output logic        stale,
  output logic [7:0]  glitch_count
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

  logic [3:0]       trg_q;
  logic [7:0]       seg_q;
  logic             pos_valid;
  logic [1:0]       pos_idx;
  logic             is_glitch;
  logic [9:0]       cur_key;
  logic [9:0]       ref_key;
  logic [SW-1:0]    stab_cnt;
  scan_state_t      state;
  logic             latch;
  seg_decode_t      dec;
  logic [3:0][3:0]  slot_digit;
  logic [3:0]       slot_blank;
  logic [3:0]       slot_invalid;
  logic [3:0]       slot_dp;
  logic [3:0]       seen;
  logic [TW-1:0]    tmo_cnt;

  // Input register stage; idle lines reset to "nothing driven" so the first
  // sample after reset is not mistaken for a multi-anode glitch.
  always_ff @(posedge MegaClk or posedge reset) begin
    if (reset) begin
      trg_q <= 4'hF;
      seg_q <= 8'hFF;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      trg_q <= trigger;
      seg_q <= segBits;
    end
  end

  // Classify the registered anode lines into none / single position / glitch.
  always_comb begin
    pos_valid = 1'b0;
    pos_idx   = 2'd0;
    is_glitch = 1'b0;
    case (trg_q)
      4'b1110: begin pos_valid = 1'b1; pos_idx = 2'd0; end
      4'b1101: begin pos_valid = 1'b1; pos_idx = 2'd1; end
      4'b1011: begin pos_valid = 1'b1; pos_idx = 2'd2; end
      4'b0111: begin pos_valid = 1'b1; pos_idx = 2'd3; end
      4'b1111: ;
      default: is_glitch = 1'b1;
    endcase
  end

  assign cur_key = {pos_idx, seg_q};
  assign latch   = (state == TRACK) && pos_valid && (cur_key == ref_key) &&
                   (stab_cnt == STAB_LAST);

  seg_pattern_decode u_decode (
    .pattern (seg_q[6:0]),
    .result  (dec)
  );

  // Stability tracking FSM: a position must repeat identically to be accepted.
  always_ff @(posedge MegaClk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ref_key  <= '0;
      stab_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pos_valid) begin
            ref_key  <= cur_key;
            stab_cnt <= SW'(1);
            state    <= TRACK;
          end
        end
        TRACK: begin
          if (!pos_valid) begin
            state <= IDLE;
          end else if (cur_key != ref_key) begin
            ref_key  <= cur_key;
            stab_cnt <= SW'(1);
          end else begin
            stab_cnt <= stab_cnt + SW'(1);
            if (latch) state <= HELD;
          end
        end
        HELD: begin
          if (!pos_valid) begin
            state <= IDLE;
          end else if (cur_key != ref_key) begin
            ref_key  <= cur_key;
            stab_cnt <= SW'(1);
            state    <= TRACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-position slots, seen mask and frame publication.
  always_ff @(posedge MegaClk or posedge reset) begin
    if (reset) begin
      // NOTE: the slot array is only four small entries, so it is reset like
      // ordinary registers rather than left as uninitialised storage.
      slot_digit   <= '0;
      slot_blank   <= '0;
      slot_invalid <= '0;
      slot_dp      <= '0;
      seen         <= '0;
      digits_out   <= '0;
      blank_mask   <= '0;
      invalid_mask <= '0;
      dp_mask      <= '0;
      frame_valid  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (seen == 4'hF) begin
        digits_out   <= slot_digit;
        blank_mask   <= slot_blank;
        invalid_mask <= slot_invalid;
        dp_mask      <= slot_dp;
        frame_valid  <= 1'b1;
      end
      // A latch in the publish cycle starts the next frame's mask.
      seen <= ((seen == 4'hF) ? 4'h0 : seen) | (latch ? (4'b0001 << pos_idx) : 4'h0);
      if (latch) begin
        slot_digit[pos_idx]   <= dec.digit;
        slot_blank[pos_idx]   <= dec.blank;
        slot_invalid[pos_idx] <= dec.invalid;
        slot_dp[pos_idx]      <= ~seg_q[7];
      end
    end
  end

  // Saturating count of samples with more than one anode low.
  always_ff @(posedge MegaClk or posedge reset) begin
    if (reset) begin
      glitch_count <= '0;
    end else if (is_glitch && (glitch_count != 8'hFF)) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end

  // Cycles since the last accepted position, saturating at the timeout.
  always_ff @(posedge MegaClk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (latch) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_MAX) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign stale = (tmo_cnt == TMO_MAX);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed scenarios plus a random
// scan phase, all checked cycle by cycle against a behavioural model.
module tb_seg_scan_capture;

  localparam int STABLE = 4;
  localparam int TMO    = 50;

  logic        MegaClk = 1'b0;
  logic        reset;
  logic [3:0]  trigger;
  logic [7:0]  segBits;
  logic [15:0] digits_out;
  logic [3:0]  blank_mask;
  logic [3:0]  invalid_mask;
  logic [3:0]  dp_mask;
  logic        frame_valid;
  logic        stale;
  logic [7:0]  glitch_count;

  always #5 MegaClk = ~MegaClk;

  seg_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .MegaClk      (MegaClk),
    .reset        (reset),
    .trigger      (trigger),
    .segBits      (segBits),
    .digits_out   (digits_out),
    .blank_mask   (blank_mask),
    .invalid_mask (invalid_mask),
    .dp_mask      (dp_mask),
    .frame_valid  (frame_valid),
    .stale        (stale),
    .glitch_count (glitch_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int pulses;

  logic [7:0] seg_code [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Behavioural model state.
  logic [3:0]  m_prev_trg;
  logic [7:0]  m_prev_seg;
  int          m_run;
  logic [9:0]  m_key;
  logic [3:0]  m_sd [4];
  logic        m_sb [4];
  logic        m_si [4];
  logic        m_sp [4];
  logic [3:0]  m_seen;
  logic [15:0] m_digits;
  logic [3:0]  m_blank, m_inv, m_dp;
  logic        m_fv;
  int          m_glitch;
  int          m_tmo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_trg = 4'hF;
    m_prev_seg = 8'hFF;
    m_run = 0;
    m_key = '0;
    for (int i = 0; i < 4; i++) begin
      m_sd[i] = 4'd0; m_sb[i] = 1'b0; m_si[i] = 1'b0; m_sp[i] = 1'b0;
    end
    m_seen = 4'h0;
    m_digits = 16'h0;
    m_blank = 4'h0; m_inv = 4'h0; m_dp = 4'h0;
    m_fv = 1'b0;
    m_glitch = 0;
    m_tmo = 0;
  endtask

  // One clock edge of the model: the display reader acts on last cycle's sample.
  task automatic model_step(input logic [3:0] t, input logic [7:0] s);
    int   zeros;
    int   idx;
    bit   latched;
    logic [3:0] d;
    logic bl, inv;
    m_fv = 1'b0;
    if (m_seen == 4'hF) begin
      for (int i = 0; i < 4; i++) begin
        m_digits[4*i +: 4] = m_sd[i];
        m_blank[i] = m_sb[i];
        m_inv[i]   = m_si[i];
        m_dp[i]    = m_sp[i];
      end
      m_fv = 1'b1;
      m_seen = 4'h0;
    end
    latched = 1'b0;
    zeros = 4 - $countones(m_prev_trg);
    if (zeros > 1) begin
      if (m_glitch < 255) m_glitch++;
      m_run = 0;
    end else if (zeros == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!m_prev_trg[i]) idx = i;
      if (m_run > 0 && m_key == {2'(idx), m_prev_seg}) m_run++;
      else m_run = 1;
      m_key = {2'(idx), m_prev_seg};
      if (m_run == STABLE) begin
        d = 4'd0; bl = 1'b0; inv = 1'b1;
        if (m_prev_seg[6:0] == 7'h7F) begin
          bl = 1'b1; inv = 1'b0;
        end else begin
          for (int k = 0; k < 10; k++)
            if (m_prev_seg[6:0] == seg_code[k][6:0]) begin d = 4'(k); inv = 1'b0; end
        end
        m_sd[idx] = d; m_sb[idx] = bl; m_si[idx] = inv; m_sp[idx] = ~m_prev_seg[7];
        m_seen[idx] = 1'b1;
        latched = 1'b1;
      end
    end else begin
      m_run = 0;
    end
    if (latched) m_tmo = 0;
    else if (m_tmo < TMO) m_tmo++;
    m_prev_trg = t;
    m_prev_seg = s;
  endtask

  task automatic compare_all();
    check("digits_out",   32'(digits_out),   32'(m_digits));
    check("blank_mask",   32'(blank_mask),   32'(m_blank));
    check("invalid_mask", 32'(invalid_mask), 32'(m_inv));
    check("dp_mask",      32'(dp_mask),      32'(m_dp));
    check("frame_valid",  32'(frame_valid),  32'(m_fv));
    check("stale",        32'(stale),        32'(m_tmo == TMO));
    check("glitch_count", 32'(glitch_count), 32'(m_glitch));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, 32'(digits_out),   32'h0);
    check({tag, "_blank"},  32'(blank_mask),   32'h0);
    check({tag, "_inv"},    32'(invalid_mask), 32'h0);
    check({tag, "_dp"},     32'(dp_mask),      32'h0);
    check({tag, "_fv"},     32'(frame_valid),  32'h0);
    check({tag, "_stale"},  32'(stale),        32'h0);
    check({tag, "_glitch"}, 32'(glitch_count), 32'h0);
  endtask

  task automatic tick(input logic [3:0] t, input logic [7:0] s);
    trigger = t;
    segBits = s;
    @(posedge MegaClk);
    model_step(t, s);
    #1;
    compare_all();
    if (frame_valid) pulses++;
  endtask

  task automatic dwell(input int pos, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) tick(~(4'b0001 << pos), s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'hF, 8'hFF);
  endtask

  initial begin
    logic [3:0] t;
    logic [7:0] s;
    int first_stale;
    logic [3:0] glitch_pats [6] = '{4'b1100, 4'b1010, 4'b0110, 4'b0101, 4'b0000, 4'b1000};

    // Reset state.
    reset = 1'b1;
    trigger = 4'hF;
    segBits = 8'hFF;
    model_reset();
    #12;
    check_zero("reset");
    reset = 1'b0;

    // Basic frame 3210.
    pulses = 0;
    dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8); dwell(3, 8'hB0, 8);
    idle(3);
    check("basic_pulses", 32'(pulses), 32'd1);
    check("basic_digits", 32'(digits_out), 32'h3210);
    check("basic_masks",  32'({blank_mask, invalid_mask, dp_mask}), 32'h0);

    // Short dwell on position 2 must not latch.
    pulses = 0;
    dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hF8, 3); dwell(3, 8'hB0, 8);
    check("short_dwell_no_frame", 32'(pulses), 32'd0);
    dwell(2, 8'hF8, 4);
    idle(3);
    check("full_dwell_pulses", 32'(pulses), 32'd1);
    check("full_dwell_digits", 32'(digits_out), 32'h3710);

    // Blank upper positions, dp on position 1.
    pulses = 0;
    dwell(0, 8'h90, 8); dwell(1, 8'h12, 8); dwell(2, 8'hFF, 8); dwell(3, 8'hFF, 8);
    idle(3);
    check("blank_pulses", 32'(pulses), 32'd1);
    check("blank_digits", 32'(digits_out), 32'h0059);
    check("blank_mask",   32'(blank_mask), 32'hC);
    check("blank_dp",     32'(dp_mask), 32'h2);
    check("blank_inv",    32'(invalid_mask), 32'h0);

    // Invalid patterns, blank-with-dp, digit 8.
    dwell(0, 8'hFE, 8); dwell(1, 8'h7F, 8); dwell(2, 8'h80, 8); dwell(3, 8'h01, 8);
    idle(3);
    check("inv_digits", 32'(digits_out), 32'h0800);
    check("inv_mask",   32'(invalid_mask), 32'h9);
    check("inv_blank",  32'(blank_mask), 32'h2);
    check("inv_dp",     32'(dp_mask), 32'hA);

    // Glitch counting and saturation.
    pulses = 0;
    for (int i = 0; i < 3; i++) tick(4'b1100, 8'hC0);
    idle(1);
    check("glitch_3", 32'(glitch_count), 32'd3);
    check("glitch_no_frame", 32'(pulses), 32'd0);
    for (int i = 0; i < 300; i++) tick(4'b1100, 8'hC0);
    idle(1);
    check("glitch_sat", 32'(glitch_count), 32'd255);

    // Random scanning against the model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0:       t = 4'hF;
        1:       t = glitch_pats[$urandom_range(0, 5)];
        default: t = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0, 1: begin s = seg_code[$urandom_range(0, 9)]; s[7] = 1'($urandom_range(0, 1)); end
        2:    s = {1'($urandom_range(0, 1)), 7'h7F};
        default: s = 8'($urandom);
      endcase
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) tick(t, s);
    end

    // Async reset while tracking position 3.
    dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8);
    dwell(3, 8'hB0, 2);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge MegaClk);
    #1 check_zero("reset_held");
    reset = 1'b0;
    pulses = 0;
    dwell(3, 8'hB0, 8);
    idle(2);
    check("post_reset_no_frame", 32'(pulses), 32'd0);
    dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8);
    idle(3);
    check("post_reset_pulses", 32'(pulses), 32'd1);
    check("post_reset_digits", 32'(digits_out), 32'h3210);

    // Timeout: fresh reset, then idle lines. The counter reaches TMO on the
    // 50th edge after release, i.e. stale is visible during cycle 51.
    @(negedge MegaClk);
    reset = 1'b1;
    model_reset();
    @(negedge MegaClk);
    reset = 1'b0;
    first_stale = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(4'hF, 8'hFF);
      if (stale && first_stale < 0) first_stale = i;
    end
    check("stale_rise_edge", 32'(first_stale), 32'd50);
    dwell(0, 8'hC0, 4);
    check("stale_before_latch", 32'(stale), 32'd1);
    dwell(0, 8'hC0, 1);
    check("stale_cleared", 32'(stale), 32'd0);
    dwell(0, 8'hC0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
